// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Turns hazard-unit stall/flush requests, branch flushes and bus waits into
//   per-stage enable/flush controls for the 5-stage pipeline. A load-use stall
//   is held for STALL_CYCLES bubbles by a small RUN/STALL FSM. Saturating
//   performance counters track stall cycles and accepted flushes.
//
//   Ports
//     clk, rst_n       core clock, asynchronous active-low reset
//     stall_and_flush  [1]=stall request, [0]=flush request (hazard unit)
//     branch_flush     taken branch/jump resolved in EX
//     if_busy          instruction fetch not yet acked
//     mem_busy         data access in MEM not yet acked
//     pc_en            PC load enable
//     ifid_en/_flush   IF/ID enable / load bubble
//     idex_en/_flush   ID/EX enable / load bubble
//     exmem_en         EX/MEM enable
//     memwb_en         MEM/WB enable
//     stall_cnt        cycles spent in hazard stall (saturating)
//     flush_cnt        accepted flush events (saturating)
module pipeline_ctrl #(
  parameter int STALL_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           stall_and_flush,
  input  logic                 branch_flush,
  input  logic                 if_busy,
  input  logic                 mem_busy,
  output logic                 pc_en,
  output logic                 ifid_en,
  output logic                 ifid_flush,
  output logic                 idex_en,
  output logic                 idex_flush,
  output logic                 exmem_en,
  output logic                 memwb_en,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  // Bubble counter only needs to hold STALL_CYCLES-2 (first bubble is issued from RUN).
  localparam int BW = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES - 1) : 1;
  localparam logic [BW-1:0] BUB_LOAD = BW'((STALL_CYCLES > 1) ? STALL_CYCLES - 2 : 0);

  typedef enum logic {RUN, STALL} state_t;

  state_t          state;
  logic [BW-1:0]   bub_cnt;
  logic            flush_req;
  logic            stall_req;
  logic            stall_act;

  assign flush_req = branch_flush | stall_and_flush[0];
  assign stall_req = stall_and_flush[1];
  assign stall_act = (state == STALL) | stall_req;

  // Controls are combinational so a request takes effect in the same cycle.
  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    if (!rst_n || mem_busy) begin
      // everything frozen
    end else if (flush_req) begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (stall_act) begin
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (if_busy) begin
      ifid_en    = 1'b1;
      ifid_flush = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en      = 1'b1;
      ifid_en    = 1'b1;
      idex_en    = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      bub_cnt   <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (mem_busy) begin
      // hold FSM and counters while the bus is waiting
    end else if (flush_req) begin
      state   <= RUN;
      bub_cnt <= '0;
      if (flush_cnt != '1) flush_cnt <= flush_cnt + CNT_WIDTH'(1);
    end else if (stall_act) begin
      if (stall_cnt != '1) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (state == STALL) begin
        if (bub_cnt == '0) state <= RUN;
        else               bub_cnt <= bub_cnt - BW'(1);
      end else if (STALL_CYCLES > 1) begin
        state   <= STALL;
        bub_cnt <= BUB_LOAD;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl: three instances with different STALL_CYCLES /
// CNT_WIDTH share one stimulus stream and are checked every cycle against a
// behavioural model that tracks "stall cycles still owed" per instance.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] sf = 2'b00;
  logic       bf = 1'b0, ifb = 1'b0, mb = 1'b0;

  always #5 clk = ~clk;

  // instance 0: STALL_CYCLES=1 CNT=16; 1: STALL_CYCLES=3 CNT=4; 2: STALL_CYCLES=2 CNT=16
  logic [6:0]  ctl  [3];
  logic [15:0] scnt [3];
  logic [15:0] fcnt [3];
  logic [15:0] s0, f0, s2, f2;
  logic [3:0]  s1, f1;

  pipeline_ctrl #(.STALL_CYCLES(1), .CNT_WIDTH(16)) u0 (
    .clk(clk), .rst_n(rst_n), .stall_and_flush(sf), .branch_flush(bf),
    .if_busy(ifb), .mem_busy(mb),
    .pc_en(ctl[0][6]), .ifid_en(ctl[0][5]), .ifid_flush(ctl[0][4]), .idex_en(ctl[0][3]),
    .idex_flush(ctl[0][2]), .exmem_en(ctl[0][1]), .memwb_en(ctl[0][0]),
    .stall_cnt(s0), .flush_cnt(f0));

  pipeline_ctrl #(.STALL_CYCLES(3), .CNT_WIDTH(4)) u1 (
    .clk(clk), .rst_n(rst_n), .stall_and_flush(sf), .branch_flush(bf),
    .if_busy(ifb), .mem_busy(mb),
    .pc_en(ctl[1][6]), .ifid_en(ctl[1][5]), .ifid_flush(ctl[1][4]), .idex_en(ctl[1][3]),
    .idex_flush(ctl[1][2]), .exmem_en(ctl[1][1]), .memwb_en(ctl[1][0]),
    .stall_cnt(s1), .flush_cnt(f1));

  pipeline_ctrl #(.STALL_CYCLES(2), .CNT_WIDTH(16)) u2 (
    .clk(clk), .rst_n(rst_n), .stall_and_flush(sf), .branch_flush(bf),
    .if_busy(ifb), .mem_busy(mb),
    .pc_en(ctl[2][6]), .ifid_en(ctl[2][5]), .ifid_flush(ctl[2][4]), .idex_en(ctl[2][3]),
    .idex_flush(ctl[2][2]), .exmem_en(ctl[2][1]), .memwb_en(ctl[2][0]),
    .stall_cnt(s2), .flush_cnt(f2));

  assign scnt[0] = s0;
  assign fcnt[0] = f0;
  assign scnt[1] = 16'(s1);
  assign fcnt[1] = 16'(f1);
  assign scnt[2] = s2;
  assign fcnt[2] = f2;

  // ---------------- reference model ----------------
  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  localparam logic [6:0] C_NORM  = 7'b1101011;
  localparam logic [6:0] C_FLUSH = 7'b1111111;
  localparam logic [6:0] C_STALL = 7'b0001111;
  localparam logic [6:0] C_IFB   = 7'b0111011;
  localparam logic [6:0] C_OFF   = 7'b0000000;

  int         scy  [3] = '{1, 3, 2};
  int         cmax [3] = '{65535, 15, 65535};
  int         owed [3];   // stall cycles still owed after the current one
  int         sc   [3];
  int         fc   [3];
  logic [6:0] exp_ctl [3];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic model_expect();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n || mb)                 exp_ctl[k] = C_OFF;
      else if (bf || sf[0])             exp_ctl[k] = C_FLUSH;
      else if (owed[k] > 0 || sf[1])    exp_ctl[k] = C_STALL;
      else if (ifb)                     exp_ctl[k] = C_IFB;
      else                              exp_ctl[k] = C_NORM;
    end
  endtask

  task automatic model_commit();
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        owed[k] = 0; sc[k] = 0; fc[k] = 0;
      end else if (mb) begin
      end else if (bf || sf[0]) begin
        owed[k] = 0;
        if (fc[k] < cmax[k]) fc[k]++;
      end else if (owed[k] > 0 || sf[1]) begin
        if (owed[k] > 0) owed[k]--;
        else             owed[k] = scy[k] - 1;
        if (sc[k] < cmax[k]) sc[k]++;
      end
    end
  endtask

  // drive inputs just after posedge, then move to the sampling point
  task automatic apply(input logic [1:0] s, input logic b, input logic i, input logic m);
    sf = s; bf = b; ifb = i; mb = m;
    model_expect();
    @(negedge clk);
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    apply(2'b00, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({ctl[k], scnt[k], fcnt[k]} !== {C_OFF, 16'd0, 16'd0}) begin
        n_fail++;
        $display("FAIL reset_hold inst%0d ctl=%b s=%0d f=%0d exp ctl=%b s=0 f=0",
                 k, ctl[k], scnt[k], fcnt[k], C_OFF);
      end
    end
    advance();
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      apply(2'b00, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if ({ctl[k], scnt[k], fcnt[k]} !== {C_NORM, 16'd0, 16'd0}) begin
          n_fail++;
          $display("FAIL reset_idle inst%0d ctl=%b s=%0d f=%0d exp ctl=%b s=0 f=0",
                   k, ctl[k], scnt[k], fcnt[k], C_NORM);
        end
      end
      advance();
    end
  endtask

  // scripted sequences: {sf, bf, ifb, mb} per cycle, checked against the model
  task automatic test_script(input string nm, input logic [4:0] seq [$]);
    foreach (seq[c]) begin
      apply(seq[c][4:3], seq[c][2], seq[c][1], seq[c][0]);
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if ({ctl[k], scnt[k], fcnt[k]} !== {exp_ctl[k], 16'(sc[k]), 16'(fc[k])}) begin
          n_fail++;
          $display("FAIL %s cyc%0d inst%0d ctl=%b s=%0d f=%0d exp ctl=%b s=%0d f=%0d",
                   nm, c, k, ctl[k], scnt[k], fcnt[k], exp_ctl[k], sc[k], fc[k]);
        end
      end
      advance();
    end
  endtask

  task automatic test_saturation_reset();
    logic [4:0] q [$];
    for (int i = 0; i < 20; i++) q.push_back(5'b00100);   // 20 branch flushes
    q.push_back(5'b00000);
    q.push_back(5'b10000);                                // start a stall
    q.push_back(5'b00000);
    test_script("flush_sat", q);
    n_tests++;
    if (f1 !== 4'd15) begin
      n_fail++;
      $display("FAIL flush_sat_cnt4 got %0d exp 15", f1);
    end
    // async reset while instance 1 is mid-STALL
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if ({ctl[k], scnt[k], fcnt[k]} !== {C_OFF, 16'd0, 16'd0}) begin
        n_fail++;
        $display("FAIL async_reset inst%0d ctl=%b s=%0d f=%0d exp ctl=%b s=0 f=0",
                 k, ctl[k], scnt[k], fcnt[k], C_OFF);
      end
    end
    model_commit();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    q.push_back(5'b00000);
    q.push_back(5'b00000);
    test_script("post_reset", q);
  endtask

  task automatic test_random();
    logic [4:0] q [$];
    logic [4:0] v;
    for (int i = 0; i < 400; i++) begin
      v[4] = ($urandom_range(0, 5) == 0);
      v[3] = ($urandom_range(0, 9) == 0);
      v[2] = ($urandom_range(0, 9) == 0);
      v[1] = ($urandom_range(0, 3) == 0);
      v[0] = ($urandom_range(0, 5) == 0);
      q.push_back(v);
    end
    test_script("random", q);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      owed[k] = 0; sc[k] = 0; fc[k] = 0;
    end
    @(posedge clk);
    #1;
    test_reset();
    // single stall request, then idle
    test_script("single_stall", '{5'b10000, 5'b00000, 5'b00000, 5'b00000, 5'b00000});
    // stall request, branch flush on the 2nd cycle
    test_script("stall_flush", '{5'b10000, 5'b00100, 5'b00000, 5'b00000});
    // stall, then mem_busy for 4 cycles, then release
    test_script("mem_busy", '{5'b10000, 5'b00001, 5'b00001, 5'b00001, 5'b00001,
                              5'b00000, 5'b00000, 5'b00000});
    // stall_and_flush=11 with if_busy: flush wins
    test_script("flush_wins", '{5'b11010, 5'b00010, 5'b00000});
    test_random();
    test_saturation_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
